seq_detector_param: RTL and testbench

Parametrised serial pattern detector and the successor to the fixed 3-bit "110" detector used on the board. Two push-button-style inputs supply one bit per sample tick. A programmable pattern of up to 16 bits is matched against the most recent bits, in run-time-selectable overlapping or non-overlapping mode. The sample tick is an internal clock-enable derived from `clk`; there is no derived clock. Outputs drive board LEDs: match flag, bit history and match count.

---
 rtl/seq_detector_param_if.sv | 36 +++
 rtl/seq_detector_param.sv | 100 ++++++++++
 tb/tb_seq_detector_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - signal bundle for the serial pattern detector
//
// Purpose: groups the detector's input requests and LED-facing outputs.
// Ports (signals):
//   in1, in0   "bit = 1" / "bit = 0" requests, level-sampled on tick
//   ovl        1 = overlapping detection, 0 = non-overlapping
//   tick       one-clk pulse marking each sample instant
//   match      pattern detected at the last tick
//   err        both requests high at the last tick
//   hist       last N accepted bits, hist[0] newest
//   match_cnt  saturating match counter
// Modports: master drives the requests; slave is the detector.
`timescale 1ns/1ps
interface seq_detector_param_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic             in1;
  logic             in0;
  logic             ovl;
  logic             tick;
  logic             match;
  logic             err;
  logic [N-1:0]     hist;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in1, in0, ovl,
    input  tick, match, err, hist, match_cnt
  );

  modport slave (
    input  in1, in0, ovl,
    output tick, match, err, hist, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with sample tick
//
// Purpose: one bit per sample tick is taken from two push-button requests and
// matched against an N-bit PATTERN (MSB oldest), in overlapping or
// non-overlapping mode selected at run time.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seq_detector_param_if.slave (in1, in0, ovl in; tick, match, err,
//         hist, match_cnt out)
`timescale 1ns/1ps
module seq_detector_param #(
  parameter int           N        = 3,
  parameter logic [N-1:0] PATTERN  = 3'b110,
  parameter int           TICK_DIV = 50_000_000,
  parameter int           CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int               FILL_W    = $clog2(N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [DIV_W-1:0]  div_q,   div_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic [N-1:0]      hist_q,  hist_d;
  logic              match_q, match_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              tick;
  logic              bit_valid;
  logic [N-1:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // With TICK_DIV=1 DIV_LAST is 0 and div never leaves 0, so tick stays high.
  assign tick       = (div_q == DIV_LAST);
  // Exactly one request high means a bit; its value is in1.
  assign bit_valid  = bus.in1 ^ bus.in0;
  assign hist_shift = {hist_q[N-2:0], bus.in1};
  assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
  assign hit        = bit_valid && (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    fill_d  = fill_q;
    hist_d  = hist_q;
    match_d = match_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (tick) begin
      err_d   = bus.in1 & bus.in0;
      match_d = hit;
      if (bit_valid) begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
      if (hit) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Non-overlapping: demand N fresh bits; hist is kept for the LEDs.
        if (!bus.ovl) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      fill_q  <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      match_q <= match_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.match     = match_q;
  assign bus.err       = err_q;
  assign bus.hist      = hist_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
`timescale 1ns/1ps
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in1 = 1'b0;
  logic in0 = 1'b0;
  logic ovl = 1'b0;

  always #5 clk = ~clk;

  // a: N=3 "110"; b: N=4 "1010"; c: N=3 "110" with 2-bit counter; d: TICK_DIV=1
  seq_detector_param_if #(.N(3), .CNT_W(8)) bus_a ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) bus_b ();
  seq_detector_param_if #(.N(3), .CNT_W(2)) bus_c ();
  seq_detector_param_if #(.N(3), .CNT_W(8)) bus_d ();

  assign bus_a.in1 = in1; assign bus_a.in0 = in0; assign bus_a.ovl = ovl;
  assign bus_b.in1 = in1; assign bus_b.in0 = in0; assign bus_b.ovl = ovl;
  assign bus_c.in1 = in1; assign bus_c.in0 = in0; assign bus_c.ovl = ovl;
  assign bus_d.in1 = in1; assign bus_d.in0 = in0; assign bus_d.ovl = ovl;

  seq_detector_param #(.N(3), .PATTERN(3'b110), .TICK_DIV(4), .CNT_W(8))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_detector_param #(.N(4), .PATTERN(4'b1010), .TICK_DIV(4), .CNT_W(8))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  seq_detector_param #(.N(3), .PATTERN(3'b110), .TICK_DIV(4), .CNT_W(2))
    u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  seq_detector_param #(.N(3), .PATTERN(3'b110), .TICK_DIV(1), .CNT_W(8))
    u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));

  logic [15:0] o_hist [3];
  logic [7:0]  o_cnt  [3];
  logic        o_match[3];
  logic        o_err  [3];

  assign o_hist[0] = 16'(bus_a.hist);  assign o_cnt[0] = 8'(bus_a.match_cnt);
  assign o_hist[1] = 16'(bus_b.hist);  assign o_cnt[1] = 8'(bus_b.match_cnt);
  assign o_hist[2] = 16'(bus_c.hist);  assign o_cnt[2] = 8'(bus_c.match_cnt);
  assign o_match[0] = bus_a.match;     assign o_err[0] = bus_a.err;
  assign o_match[1] = bus_b.match;     assign o_err[1] = bus_b.err;
  assign o_match[2] = bus_c.match;     assign o_err[2] = bus_c.err;

  typedef struct packed {
    logic        match;
    logic        err;
    logic [15:0] hist;
    logic [7:0]  cnt;
    logic [7:0]  fill;
  } exp_t;

  exp_t sb_q[$];

  int          mn[3] = '{3, 4, 3};
  logic [15:0] mp[3] = '{16'h0006, 16'h000A, 16'h0006};
  int          mc[3] = '{255, 255, 3};

  logic [15:0] m_hist [3];
  int          m_fill [3];
  int          m_cnt  [3];
  logic        m_match[3];
  logic        m_err  [3];
  int          m_div = 0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference divider for TICK_DIV=4.
  always @(posedge clk) begin
    m_div <= (rst || m_div == 3) ? 0 : m_div + 1;
  end

  // Outputs must hold the committed model state on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("tick_a", 32'(bus_a.tick), 32'(m_div == 3));
      check_val("tick_b", 32'(bus_b.tick), 32'(m_div == 3));
      check_val("tick_c", 32'(bus_c.tick), 32'(m_div == 3));
      check_val("tick_d", 32'(bus_d.tick), 32'd1);
      for (int k = 0; k < 3; k++) begin
        check_val($sformatf("hold_match%0d", k), 32'(o_match[k]), 32'(m_match[k]));
        check_val($sformatf("hold_err%0d", k),   32'(o_err[k]),   32'(m_err[k]));
        check_val($sformatf("hold_hist%0d", k),  32'(o_hist[k]),  32'(m_hist[k]));
        check_val($sformatf("hold_cnt%0d", k),   32'(o_cnt[k]),   32'(m_cnt[k]));
      end
    end
  end

  function automatic exp_t model_next(input int k, input logic i1, input logic i0, input logic o);
    exp_t        e;
    logic [15:0] mask;
    int          f;
    mask    = 16'((32'd1 << mn[k]) - 32'd1);
    e.hist  = m_hist[k];
    e.cnt   = 8'(m_cnt[k]);
    e.fill  = 8'(m_fill[k]);
    e.err   = i1 & i0;
    e.match = 1'b0;
    if (i1 != i0) begin
      e.hist = ((m_hist[k] << 1) | {15'd0, i1}) & mask;
      f = (m_fill[k] >= mn[k]) ? mn[k] : m_fill[k] + 1;
      if (f == mn[k] && e.hist == mp[k]) begin
        e.match = 1'b1;
        if (m_cnt[k] < mc[k]) e.cnt = 8'(m_cnt[k] + 1);
        if (!o) f = 0;
      end
      e.fill = 8'(f);
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = '0; m_fill[k] = 0; m_cnt[k] = 0; m_match[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  // Drive one tick's worth of input and score the result at that tick edge.
  task automatic step(input logic i1, input logic i0, input logic o);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (m_div != 3 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (m_div != 3) check_val("tick_wait", 32'(m_div), 32'd3);
    in1 = i1; in0 = i0; ovl = o;
    for (int k = 0; k < 3; k++) sb_q.push_back(model_next(k, i1, i0, o));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      check_val($sformatf("edge_match%0d", k), 32'(o_match[k]), 32'(e.match));
      check_val($sformatf("edge_err%0d", k),   32'(o_err[k]),   32'(e.err));
      check_val($sformatf("edge_hist%0d", k),  32'(o_hist[k]),  32'(e.hist));
      check_val($sformatf("edge_cnt%0d", k),   32'(o_cnt[k]),   32'(e.cnt));
      m_hist[k] = e.hist; m_cnt[k] = int'(e.cnt); m_fill[k] = int'(e.fill);
      m_match[k] = e.match; m_err[k] = e.err;
    end
    in1 = 1'b0; in0 = 1'b0;
  endtask

  task automatic do_reset(input int cycles, input logic at_tick);
    int g = 0;
    @(negedge clk);
    if (at_tick) begin
      while (m_div != 3 && g < 8) begin
        @(negedge clk);
        g++;
      end
      in1 = 1'b1; in0 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    in1 = 1'b0; in0 = 1'b0;
    repeat (cycles - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_match%0d", k), 32'(o_match[k]), 32'd0);
      check_val($sformatf("rst_hist%0d", k),  32'(o_hist[k]),  32'd0);
      check_val($sformatf("rst_cnt%0d", k),   32'(o_cnt[k]),   32'd0);
    end
  endtask

  initial begin
    model_clear();
    do_reset(10, 1'b0);
    chk_en = 1'b1;

    // Basic detect, then one more bit.
    step(1, 0, 1); step(1, 0, 1); step(0, 1, 1);
    check_val("s2_match", 32'(o_match[0]), 32'd1);
    check_val("s2_cnt",   32'(o_cnt[0]),   32'd1);
    check_val("s2_hist",  32'(o_hist[0]),  32'h6);
    step(1, 0, 1);
    check_val("s2_match_off", 32'(o_match[0]), 32'd0);
    check_val("s2_hist2",     32'(o_hist[0]),  32'h5);

    // Overlapping 1010 stream.
    do_reset(3, 1'b0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, 1);
    check_val("s3_cnt",   32'(o_cnt[1]),   32'd2);
    check_val("s3_match", 32'(o_match[1]), 32'd1);

    // Non-overlapping: only the 4th bit matches; two more bits complete the next one.
    do_reset(3, 1'b0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, 0);
    check_val("s4_cnt",   32'(o_cnt[1]),   32'd1);
    check_val("s4_match", 32'(o_match[1]), 32'd0);
    step(1, 0, 0); step(0, 1, 0);
    check_val("s4_refill", 32'(o_match[1]), 32'd1);

    // Error tick and idle tick.
    do_reset(3, 1'b0);
    step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
    check_val("s5_err",  32'(o_err[0]),  32'd1);
    check_val("s5_hist", 32'(o_hist[0]), 32'h3);
    step(0, 1, 1);
    check_val("s5_match", 32'(o_match[0]), 32'd1);
    check_val("s5_err_clr", 32'(o_err[0]), 32'd0);
    step(0, 0, 1);
    check_val("s5_idle_hist",  32'(o_hist[0]),  32'h6);
    check_val("s5_idle_match", 32'(o_match[0]), 32'd0);

    // Reset mid-sequence, including reset coincident with a tick carrying a bit.
    do_reset(3, 1'b0);
    step(1, 0, 1); step(1, 0, 1);
    do_reset(1, 1'b1);
    step(0, 1, 1);
    check_val("s6_nomatch", 32'(o_match[0]), 32'd0);
    check_val("s6_hist",    32'(o_hist[0]),  32'h0);
    step(1, 0, 1); step(1, 0, 1); step(0, 1, 1);
    check_val("s6_match", 32'(o_match[0]), 32'd1);

    // Saturation of the 2-bit counter.
    do_reset(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0); step(1, 0, 0); step(0, 1, 0);
    end
    check_val("sat_cnt_c", 32'(o_cnt[2]), 32'd3);
    check_val("sat_cnt_a", 32'(o_cnt[0]), 32'd5);

    // Random stream with random mode changes.
    for (int i = 0; i < 80; i++) begin
      logic r1, r0, ro;
      r1 = 1'($urandom_range(0, 1));
      r0 = ($urandom_range(0, 3) == 0) ? r1 : ~r1;
      ro = ($urandom_range(0, 7) != 0) ? ovl : ~ovl;
      step(r1, r0, ro);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
